// File: rtl/ppm_encoder.sv
// Multi-channel CPPM transmitter: serialises NUM_CH 8-bit channel values into one
// PPM stream with active-high separator pulses, one frame every FRAME_TICKS clocks.
// Bus writes land in shadow registers; shadows are copied to the active set at
// frame start so a frame never changes mid-flight.
// Optional feature: define PPM_FAILSAFE_EN to substitute DEFAULT_VAL for every
// channel on frames that start while link_ok is low.
module ppm_encoder #(
  parameter int unsigned NUM_CH      = 6,
  parameter int unsigned FRAME_TICKS = 5100,
  parameter int unsigned SEP_TICKS   = 102,
  parameter int unsigned DEFAULT_VAL = 127
) (
  input  logic       clk_255kHz,
  input  logic       reset,
  input  logic       ch_wr_en,
  input  logic [2:0] ch_wr_addr,
  input  logic [7:0] ch_wr_data,
  input  logic       link_ok,
  output logic       ppm,
  output logic       frame_start
);

  typedef enum logic [1:0] {StPulse, StGap, StEndPulse, StSync} state_e;

  localparam logic [9:0]  SepLen    = 10'(SEP_TICKS);
  localparam logic [12:0] FrameLast = 13'(FRAME_TICKS - 1);
  localparam logic [2:0]  LastCh    = 3'(NUM_CH - 1);
  localparam logic [7:0]  DefVal    = 8'(DEFAULT_VAL);

  logic [12:0] frame_cnt_q, frame_cnt_d;
  logic        frame_start_q, frame_start_d;
  logic        ppm_q, ppm_d;
  state_e      state_q, state_d;
  logic [2:0]  ch_q, ch_d;
  logic [9:0]  tick_q, tick_d;
  logic [7:0]  shadow_q [NUM_CH];
  logic [7:0]  shadow_d [NUM_CH];
  logic [7:0]  active_q [NUM_CH];
  logic [7:0]  active_d [NUM_CH];

  logic        frame_zero;
  logic [7:0]  cur_val;
  logic [9:0]  gap_len;

  assign frame_zero = (frame_cnt_q == '0);

`ifndef PPM_FAILSAFE_EN
  logic unused_link_ok;
  assign unused_link_ok = link_ok;
`endif

  // Frame counter, frame_start pulse, shadow writes and frame-start copy.
  always_comb begin
    frame_cnt_d   = (frame_cnt_q == FrameLast) ? '0 : frame_cnt_q + 13'd1;
    frame_start_d = frame_zero;
    shadow_d      = shadow_q;
    active_d      = active_q;
    // Loop decode so out-of-range addresses simply match nothing.
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_wr_en && (ch_wr_addr == 3'(i))) shadow_d[i] = ch_wr_data;
    end
    // Copy reads shadow_q, so a write on this same cycle lands next frame.
    if (frame_zero) begin
      for (int i = 0; i < NUM_CH; i++) begin
`ifdef PPM_FAILSAFE_EN
        active_d[i] = link_ok ? shadow_q[i] : DefVal;
`else
        active_d[i] = shadow_q[i];
`endif
      end
    end
  end

  // Select the active value of the channel currently being timed.
  always_comb begin
    cur_val = active_q[0];
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_q == 3'(i)) cur_val = active_q[i];
    end
  end

  // Slot = 255 + value ticks; the gap is the slot minus the separator pulse.
  assign gap_len = 10'd255 + {2'b00, cur_val} - SepLen;

  // Channel FSM next state and registered ppm level.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    tick_d  = tick_q + 10'd1;
    if (frame_zero) begin
      // Frame start always restarts channel 0, so ppm rises one tick later.
      state_d = StPulse;
      ch_d    = '0;
      tick_d  = '0;
    end else begin
      unique case (state_q)
        StPulse: begin
          if (tick_q == SepLen - 10'd1) begin
            state_d = StGap;
            tick_d  = '0;
          end
        end
        StGap: begin
          if (tick_q == gap_len - 10'd1) begin
            tick_d = '0;
            if (ch_q == LastCh) begin
              state_d = StEndPulse;
            end else begin
              state_d = StPulse;
              ch_d    = ch_q + 3'd1;
            end
          end
        end
        StEndPulse: begin
          if (tick_q == SepLen - 10'd1) begin
            state_d = StSync;
            tick_d  = '0;
          end
        end
        StSync: begin
          tick_d = tick_q;
        end
        default: begin
          state_d = StSync;
          tick_d  = '0;
        end
      endcase
    end
    // Suppressed on the frame_cnt==0 cycle so the post-reset PULSE state does not
    // raise ppm alongside frame_start.
    ppm_d = ((state_q == StPulse) || (state_q == StEndPulse)) && !frame_zero;
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk_255kHz) begin
    if (reset) begin
      frame_cnt_q   <= '0;
      frame_start_q <= 1'b0;
      ppm_q         <= 1'b0;
      state_q       <= StPulse;
      ch_q          <= '0;
      tick_q        <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= DefVal;
        active_q[i] <= DefVal;
      end
    end else begin
      frame_cnt_q   <= frame_cnt_d;
      frame_start_q <= frame_start_d;
      ppm_q         <= ppm_d;
      state_q       <= state_d;
      ch_q          <= ch_d;
      tick_q        <= tick_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
    end
  end

  assign ppm         = ppm_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_ppm_encoder.sv
// Directed bench for ppm_encoder: measures rise times and pulse widths of the PPM
// stream per frame and compares them with hand-computed channel intervals.
module tb_ppm_encoder;

  localparam int Frame = 5100;
  localparam int Sep   = 102;

  logic       clk_255kHz = 1'b0;
  logic       reset;
  logic       ch_wr_en;
  logic [2:0] ch_wr_addr;
  logic [7:0] ch_wr_data;
  logic       link_ok;
  logic       ppm;
  logic       frame_start;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic ppm_prev = 1'b0;
  int rise_q[$];
  int width_q[$];
  int fs_q[$];
  int t0a, t0b, t0c, t0d, t0e, t0f, t0g, t0h, t0i;

  ppm_encoder dut (
    .clk_255kHz (clk_255kHz),
    .reset      (reset),
    .ch_wr_en   (ch_wr_en),
    .ch_wr_addr (ch_wr_addr),
    .ch_wr_data (ch_wr_data),
    .link_ok    (link_ok),
    .ppm        (ppm),
    .frame_start(frame_start)
  );

  always #5 clk_255kHz = ~clk_255kHz;

  always @(posedge clk_255kHz) cyc <= cyc + 1;

  // Record rise cycles, high widths and frame_start cycles.
  always @(negedge clk_255kHz) begin
    if (ppm === 1'b1 && ppm_prev !== 1'b1) rise_q.push_back(cyc);
    if (ppm !== 1'b1 && ppm_prev === 1'b1 && rise_q.size() > 0)
      width_q.push_back(cyc - rise_q[$]);
    if (frame_start === 1'b1) fs_q.push_back(cyc);
    ppm_prev <= ppm;
  end

  task automatic chk(input logic [31:0] act, input logic [31:0] exp, input string tag);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk_255kHz);
  endtask

  task automatic write_ch(input logic [2:0] addr, input logic [7:0] data);
    ch_wr_en   = 1'b1;
    ch_wr_addr = addr;
    ch_wr_data = data;
    @(negedge clk_255kHz);
    ch_wr_en   = 1'b0;
  endtask

  // Check the 7 rises of the frame starting at t0 against the given intervals.
  task automatic check_frame(input int t0, input int iv [6], input string tag);
    int idx, n, exp_t;
    idx = -1;
    n   = 0;
    foreach (rise_q[i]) begin
      if (rise_q[i] >= t0 && rise_q[i] < t0 + Frame) begin
        if (idx < 0) idx = i;
        n++;
      end
    end
    chk(n, 7, {tag, " rise count"});
    if (n == 7) begin
      exp_t = t0 + 1;
      for (int k = 0; k < 7; k++) begin
        chk(rise_q[idx+k], exp_t, $sformatf("%s rise%0d", tag, k));
        chk((idx + k < width_q.size()) ? width_q[idx+k] : -1, Sep,
            $sformatf("%s width%0d", tag, k));
        if (k < 6) exp_t += iv[k];
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    ch_wr_en   = 1'b0;
    ch_wr_addr = '0;
    ch_wr_data = '0;
    link_ok    = 1'b1;
    repeat (3) @(negedge clk_255kHz);
    chk(ppm, 0, "reset ppm");
    chk(frame_start, 0, "reset frame_start");
    reset = 1'b0;
    @(negedge clk_255kHz);
    chk(frame_start, 1, "first frame_start after reset");
    t0a = cyc;
    t0b = t0a + Frame;
    t0c = t0b + Frame;
    t0d = t0c + Frame;
    t0e = t0d + Frame;

    // Mid-frame writes affect only the next frame.
    wait_until(t0a + 2000);
    write_ch(3'd0, 8'd0);
    write_ch(3'd1, 8'd255);
    wait_until(t0b + 5);
    check_frame(t0a, '{382, 382, 382, 382, 382, 382}, "A default");

    // Write sampled on the frame_cnt==0 edge of frame C.
    wait_until(t0c - 1);
    write_ch(3'd2, 8'd200);
    chk(frame_start, 1, "frame_start C");
    check_frame(t0b, '{255, 510, 382, 382, 382, 382}, "B ch0/ch1");
    wait_until(t0d + 5);
    check_frame(t0c, '{255, 510, 382, 382, 382, 382}, "C ch2 deferred");
    wait_until(t0e + 5);
    check_frame(t0d, '{255, 510, 455, 382, 382, 382}, "D ch2 applied");
    for (int k = 1; k < 5; k++) chk(fs_q[k] - fs_q[k-1], Frame, $sformatf("fs period%0d", k));

    // Reset during the ch1 separator pulse (t0e+256..357).
    wait_until(t0e + 300);
    chk(ppm, 1, "ppm high before reset");
    reset = 1'b1;
    @(negedge clk_255kHz);
    chk(ppm, 0, "ppm after reset edge");
    chk(frame_start, 0, "frame_start in reset");
    repeat (2) @(negedge clk_255kHz);
    reset = 1'b0;
    @(negedge clk_255kHz);
    chk(frame_start, 1, "frame_start after mid-frame reset");
    t0f = cyc;
    t0g = t0f + Frame;
    t0h = t0g + Frame;
    t0i = t0h + Frame;

    // Out-of-range address must be ignored.
    wait_until(t0f + 100);
    write_ch(3'd6, 8'd0);
    wait_until(t0g + 5);
    check_frame(t0f, '{382, 382, 382, 382, 382, 382}, "F post-reset");
    wait_until(t0h + 5);
    check_frame(t0g, '{382, 382, 382, 382, 382, 382}, "G addr6 ignored");

    // link_ok low across frame I start; failsafe only when compiled in.
    write_ch(3'd0, 8'd0);
    link_ok = 1'b0;
    wait_until(t0i + 5);
    link_ok = 1'b1;
    wait_until(t0i + Frame + 5);
`ifdef PPM_FAILSAFE_EN
    check_frame(t0i, '{382, 382, 382, 382, 382, 382}, "I failsafe");
`else
    check_frame(t0i, '{255, 382, 382, 382, 382, 382}, "I link_ok ignored");
`endif
    wait_until(t0i + 2 * Frame + 5);
    check_frame(t0i + Frame, '{255, 382, 382, 382, 382, 382}, "J link restored");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
